// File: rtl/palette_selector_pkg.sv
// palette_selector_pkg: colour constants and the palette table shared by the palette selector.
package palette_selector_pkg;
    localparam int COLOR_WIDTH = 24;
    localparam int PALETTE_SIZE = 8;
    localparam int PAL_W = $clog2(PALETTE_SIZE);
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 24'h000000;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 24'hFFFFFF;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED = 24'hFF0000;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 24'h00FF00;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE = 24'h0000FF;
    localparam logic [COLOR_WIDTH-1:0] COLOR_YELLOW = 24'hFFFF00;
    localparam logic [COLOR_WIDTH-1:0] COLOR_CYAN = 24'h00FFFF;
    localparam logic [COLOR_WIDTH-1:0] COLOR_MAGENTA = 24'hFF00FF;
    // Entry 0 sits in the least significant slot.
    localparam logic [PALETTE_SIZE-1:0][COLOR_WIDTH-1:0] PALETTE = {
        COLOR_MAGENTA, COLOR_CYAN, COLOR_YELLOW, COLOR_BLUE,
        COLOR_GREEN, COLOR_RED, COLOR_WHITE, COLOR_BLACK
    };
    function automatic logic [COLOR_WIDTH-1:0] palette_color(input logic [PAL_W-1:0] idx);
        return PALETTE[idx];
    endfunction
endpackage

// File: rtl/palette_selector_if.sv
// palette_selector_if: control inputs and colour outputs between the UI logic and the selector.
interface palette_selector_if #(parameter int IDX_W = 3);
    import palette_selector_pkg::*;
    logic next_btn;
    logic prev_btn;
    logic load;
    logic [IDX_W-1:0] load_index;
    logic auto_en;
    logic [IDX_W-1:0] index;
    logic [COLOR_WIDTH-1:0] color;
    logic changed;
    modport master(output next_btn, prev_btn, load, load_index, auto_en, input index, color, changed);
    modport slave(input next_btn, prev_btn, load, load_index, auto_en, output index, color, changed);
endinterface

// File: rtl/palette_selector_rise_detect.sv
// palette_selector_rise_detect: one-cycle rise pulse; history resets high so a held button is not a press.
module palette_selector_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_rise
);
    logic r_q;
    always_ff @(posedge clk or posedge reset)
        r_q <= reset ? 1'b1 : i_in;
    assign o_rise = i_in & ~r_q;
endmodule

// File: rtl/palette_selector.sv
// palette_selector: steps a palette index via buttons, direct load or auto timer; registers index,
// colour and a change pulse.
module palette_selector
    import palette_selector_pkg::*;
#(
    parameter int NUM_COLORS = 5,
    parameter int RESET_INDEX = 4,
    parameter int AUTO_PERIOD = 50_000_000
) (
    input logic clk,
    input logic reset,
    palette_selector_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_COLORS);
    localparam int CNT_W = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLORS - 1);
    localparam logic [IDX_W:0] NUM_C = (IDX_W + 1)'(NUM_COLORS);
    localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_INDEX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_PERIOD - 1);

    if (NUM_COLORS < 2 || NUM_COLORS > PALETTE_SIZE) begin : g_bad_num
        $error("NUM_COLORS out of range");
    end
    if (RESET_INDEX < 0 || RESET_INDEX >= NUM_COLORS) begin : g_bad_rst
        $error("RESET_INDEX out of range");
    end
    if (AUTO_PERIOD < 1) begin : g_bad_period
        $error("AUTO_PERIOD must be at least 1");
    end

    logic w_rise_n, w_rise_p, w_load_ok, w_btn_step, w_auto_step;
    logic [IDX_W-1:0] w_inc, w_dec, w_next_idx;
    logic [CNT_W-1:0] w_next_cnt;
    logic [IDX_W-1:0] r_index;
    logic [COLOR_WIDTH-1:0] r_color;
    logic r_changed;
    logic [CNT_W-1:0] r_cnt;

    palette_selector_rise_detect u_next (.clk(clk), .reset(reset), .i_in(bus.next_btn), .o_rise(w_rise_n));
    palette_selector_rise_detect u_prev (.clk(clk), .reset(reset), .i_in(bus.prev_btn), .o_rise(w_rise_p));

    // An out-of-range load still wins priority, so it also blocks button and auto steps.
    assign w_load_ok = bus.load && ({1'b0, bus.load_index} < NUM_C);
    assign w_btn_step = w_rise_n ^ w_rise_p;
    assign w_auto_step = bus.auto_en && r_cnt == CNT_LAST;
    assign w_inc = r_index == LAST_IDX ? '0 : r_index + 1'b1;
    assign w_dec = r_index == '0 ? LAST_IDX : r_index - 1'b1;
    assign w_next_idx = w_load_ok ? bus.load_index :
                        bus.load ? r_index :
                        w_btn_step ? (w_rise_n ? w_inc : w_dec) :
                        w_auto_step ? w_inc : r_index;
    assign w_next_cnt = (bus.load || w_btn_step || !bus.auto_en || w_auto_step) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index <= RST_IDX;
            r_color <= palette_color(PAL_W'(RESET_INDEX));
            r_changed <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_index <= w_next_idx;
            r_color <= palette_color(PAL_W'(w_next_idx));
            r_changed <= w_next_idx != r_index;
            r_cnt <= w_next_cnt;
        end
    end

    assign bus.index = r_index;
    assign bus.color = r_color;
    assign bus.changed = r_changed;
endmodule

// File: tb/tb_palette_selector.sv
// tb_palette_selector: two parametrisations driven side by side against a modular-arithmetic model.
module tb_palette_selector;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    palette_selector_if #(.IDX_W(3)) bus_a ();
    palette_selector_if #(.IDX_W(2)) bus_b ();

    palette_selector #(.NUM_COLORS(5), .RESET_INDEX(4), .AUTO_PERIOD(4)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    palette_selector #(.NUM_COLORS(3), .RESET_INDEX(0), .AUTO_PERIOD(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    localparam int P = 4;
    int n_cols[2] = '{5, 3};
    int rst_idx[2] = '{4, 0};
    logic [23:0] pal[8] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
                           24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
    int m_idx[2], m_cnt[2], m_chg[2];
    bit m_pn[2], m_pp[2];
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = rst_idx[k];
            m_cnt[k] = 0;
            m_chg[k] = 0;
            m_pn[k] = 1'b1;
            m_pp[k] = 1'b1;
        end
    endtask

    task automatic model_step(input int k, input bit nb, input bit pb, input bit ld, input int li, input bit ae);
        bit rn, rp;
        int old, n;
        n = n_cols[k];
        rn = nb && !m_pn[k];
        rp = pb && !m_pp[k];
        m_pn[k] = nb;
        m_pp[k] = pb;
        old = m_idx[k];
        if (ld) begin
            if (li < n) m_idx[k] = li;
            m_cnt[k] = 0;
        end else if (rn != rp) begin
            m_idx[k] = rn ? (old + 1) % n : (old + n - 1) % n;
            m_cnt[k] = 0;
        end else if (!ae) begin
            m_cnt[k] = 0;
        end else if (m_cnt[k] == P - 1) begin
            m_cnt[k] = 0;
            m_idx[k] = (old + 1) % n;
        end else begin
            m_cnt[k]++;
        end
        m_chg[k] = int'(m_idx[k] != old);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_idx"}, int'(bus_a.index), m_idx[0]);
        chk({tag, "_a_col"}, int'(bus_a.color), int'(pal[m_idx[0]]));
        chk({tag, "_a_chg"}, int'(bus_a.changed), m_chg[0]);
        chk({tag, "_b_idx"}, int'(bus_b.index), m_idx[1]);
        chk({tag, "_b_col"}, int'(bus_b.color), int'(pal[m_idx[1]]));
        chk({tag, "_b_chg"}, int'(bus_b.changed), m_chg[1]);
    endtask

    // Called at a falling edge; drives, crosses one rising edge, checks, returns at the next falling edge.
    task automatic cyc(input bit nb, input bit pb, input bit ld, input int li_a, input int li_b, input bit ae);
        bus_a.next_btn = nb; bus_a.prev_btn = pb; bus_a.load = ld;
        bus_a.load_index = 3'(li_a); bus_a.auto_en = ae;
        bus_b.next_btn = nb; bus_b.prev_btn = pb; bus_b.load = ld;
        bus_b.load_index = 2'(li_b); bus_b.auto_en = ae;
        @(posedge clk);
        model_step(0, nb, pb, ld, li_a & 7, ae);
        model_step(1, nb, pb, ld, li_b & 3, ae);
        #1 check_all("cyc");
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_a.next_btn = 1'b1; bus_a.prev_btn = 1'b0; bus_a.load = 1'b0;
        bus_a.load_index = '0; bus_a.auto_en = 1'b0;
        bus_b.next_btn = 1'b1; bus_b.prev_btn = 1'b0; bus_b.load = 1'b0;
        bus_b.load_index = '0; bus_b.auto_en = 1'b0;
        model_reset();
        #1 check_all("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        chk("rst_hold_idx", int'(bus_a.index), 4);
        chk("rst_hold_col", int'(bus_a.color), 24'h0000FF);
        chk("rst_hold_chg", int'(bus_a.changed), 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("step_idx", int'(bus_a.index), 0);
        chk("step_col", int'(bus_a.color), 24'h000000);
        chk("step_chg", int'(bus_a.changed), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("hold_idx", int'(bus_a.index), 0);
            chk("hold_chg", int'(bus_a.changed), 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("prev_wrap_idx", int'(bus_a.index), 4);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("cancel_idx", int'(bus_a.index), 4);
        chk("cancel_chg", int'(bus_a.changed), 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 2, 2, 0);
        chk("load_idx", int'(bus_a.index), 2);
        chk("load_col", int'(bus_a.color), 24'hFF0000);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 7, 3, 0);
        chk("load_bad_idx", int'(bus_a.index), 2);
        chk("load_bad_chg", int'(bus_a.changed), 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 2, 2, 0);
        chk("load_same_chg", int'(bus_a.changed), 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            chk("auto_idx", int'(bus_a.index), (2 + i / 4) % 5);
        end
        repeat (2) cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("auto_press_idx", int'(bus_a.index), 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            chk("auto_restart_idx", int'(bus_a.index), i < 4 ? 1 : 2);
        end
        cyc(0, 0, 0, 0, 0, 1);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("async");
        chk("async_idx", int'(bus_a.index), 4);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("b_step_idx", int'(bus_b.index), i % 3);
            cyc(0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) begin
                do_reset();
            end
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 5) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/palette_selector.md
Name: palette_selector

Overview:
- Parametrised successor to the single-button colour toggle.
- Selects one colour from an N-entry palette for the drawing pipeline.
- Stepping sources: next/prev buttons (one step per press, held buttons do not repeat), a direct index load, and an optional auto-cycle timer.
- Drives the current colour and index to the pixel writer, plus a one-cycle change pulse.

Parameters:
NUM_COLORS, 5, number of active palette entries; legal range 2..PALETTE_SIZE (elaboration-time check).
RESET_INDEX, 4, index selected at reset; must be < NUM_COLORS.
AUTO_PERIOD, 50_000_000, clock cycles between auto-steps; must be >= 1.
IDX_W, $clog2(NUM_COLORS), index width (derived; do not override).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
next_btn  in  1  level; rising edge steps index +1
prev_btn  in  1  level; rising edge steps index -1
load  in  1  when high, index <= load_index on next edge
load_index  in  IDX_W  target index for load
auto_en  in  1  enables auto-cycle (+1 every AUTO_PERIOD cycles)
index  out  IDX_W  current palette index
color  out  COLOR_WIDTH  PALETTE[index]
changed  out  1  one-cycle pulse, high the cycle after index changes

Behaviour:
- Reset (async, active-high):
  - index=RESET_INDEX, color=PALETTE[RESET_INDEX], changed=0, auto counter=0.
  - Button history registers reset to 1, so a button held through reset release does not step.
- Edge detect per button: rise = btn & ~btn_q, where btn_q is the value registered on the previous edge.
  - Inputs are synchronous to clk; synchronisation and debounce happen upstream.
- Latency: a button first sampled high at edge k updates index/color at edge k. Both are registered, so new values are visible after edge k. changed is high for the cycle following edge k.
- Priority per cycle: load > button step > auto step. Only one step per cycle.
- load: if load_index >= NUM_COLORS, the load is ignored (no change, changed stays 0).
  - Loading the current index produces no change pulse.
- next and prev rising in the same cycle cancel: no step, no pulse.
- Wrap-around: +1 from NUM_COLORS-1 goes to 0; -1 from 0 goes to NUM_COLORS-1.
- Auto-cycle:
  - Counter 0..AUTO_PERIOD-1 increments while auto_en=1.
  - On reaching AUTO_PERIOD-1: it wraps to 0 and requests +1.
  - Counter clears to 0 when auto_en=0, on any load, and on any accepted button step. Manual action restarts the full period.
- color is always PALETTE[index] and is registered alongside index. No combinational path from inputs to outputs.
- changed=1 only when the index actually differs from the previous value.
- Reset asserted mid-operation returns all state to reset values immediately, regardless of clk.

Decomposition:
- Shared package (common): COLOR_WIDTH, COLOR_* constants, PALETTE_SIZE, PALETTE constant array (order BLACK, WHITE, RED, GREEN, BLUE, then extensions).
- Sub-module rise_detect (clk, reset, in, rise):
  - One instance per button.
  - Its history register resets to 1.

Test Plan:
- Reset behaviour: reset=1 two cycles, then released with next_btn held high -> index=4, color=COLOR_BLUE, changed=0, no step after release.
- Step and hold: next_btn 0->1, held 5 cycles -> index 4->0 (COLOR_BLACK) once; changed pulses exactly one cycle; index stays 0 while held.
- Reverse and cancel: prev_btn pulse at index 0 -> index 4. Then next_btn and prev_btn rising in the same cycle -> index stays 4, changed=0.
- Load rules, all with next_btn rising in the same cycle as load:
  - load_index=2 -> index=2 (COLOR_RED); the button is ignored.
  - load_index=7 -> no change.
  - load_index=2 while index=2 -> no pulse.
- Auto-cycle timing (AUTO_PERIOD=4, auto_en=1 from index 2):
  - Index becomes 3, 4, 0 at 4-cycle spacing.
  - A next_btn press mid-period restarts the count: next auto-step occurs 4 cycles after the press.
- Async reset and parameter variation:
  - Assert reset between clock edges mid-auto-cycle -> outputs return to reset values before the next edge.
  - NUM_COLORS=3, RESET_INDEX=0: next steps 0->1->2->0.
